// File: rtl/srt4_pkg.sv
// srt4_pkg: shared definitions for the radix-4 SRT quotient converter.
//   - one-hot digit bit positions as produced by the quotient-digit selection table
//   - converter FSM state encoding
//   - dig_decode(): one-hot digit -> signed value in [-2,+2] plus an illegal flag
package srt4_pkg;

  localparam int DIG_P2 = 3;
  localparam int DIG_P1 = 2;
  localparam int DIG_M1 = 1;
  localparam int DIG_M2 = 0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    WAIT_REM = 2'd2
  } otf_state_e;

  typedef struct packed {
    logic signed [2:0] val;
    logic              ill;
  } dig_dec_t;

  // A digit with more than one bit set is flagged and treated as zero so
  // the Q/QM relation still holds and the iteration count stays aligned.
  function automatic dig_dec_t dig_decode(input logic [3:0] d);
    dig_dec_t r;
    r.val = 3'sd0;
    r.ill = 1'b0;
    unique case (d)
      4'b0000: r.val = 3'sd0;
      4'b1000: r.val = 3'sd2;
      4'b0100: r.val = 3'sd1;
      4'b0010: r.val = -3'sd1;
      4'b0001: r.val = -3'sd2;
      default: r.ill = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/otf_step.sv
// otf_step: one on-the-fly conversion step (combinational).
//   q_i, qm_i  current Q and QM (QM == Q-1 mod 2^W)
//   dval_i     signed digit in [-2,+2]
//   q_o, qm_o  next Q and QM
// Because 4Q and 4QM have zero low bits, the digit terms are written straight
// into bits [1:0]; (4+q) mod 4 == q mod 4 and (3+q) mod 4 == (q-1) mod 4, so
// only the shifted source (Q or QM) depends on the digit sign.
module otf_step #(
  parameter int W = 8
) (
  input  logic [W-1:0]      q_i,
  input  logic [W-1:0]      qm_i,
  input  logic signed [2:0] dval_i,
  output logic [W-1:0]      q_o,
  output logic [W-1:0]      qm_o
);

  logic              d_neg, d_pos;
  logic signed [2:0] dm1;
  logic [W-3:0]      q_src, qm_src;

  assign d_neg  = dval_i[2];
  assign d_pos  = !dval_i[2] && (dval_i != 3'sd0);
  assign dm1    = dval_i - 3'sd1;

  assign q_src  = d_neg ? qm_i[W-3:0] : q_i[W-3:0];
  assign qm_src = d_pos ? q_i[W-3:0]  : qm_i[W-3:0];

  assign q_o    = {q_src,  dval_i[1:0]};
  assign qm_o   = {qm_src, dm1[1:0]};

endmodule

// File: rtl/otf_conv4.sv
// otf_conv4: radix-4 on-the-fly quotient converter.
// Accepts ITER signed one-hot digits per transaction, keeps Q and QM = Q-1,
// then selects Q or QM on the final remainder sign.
//   clk, reset           clock, synchronous active-high reset
//   start                begin a new quotient (highest priority, aborts)
//   digit_valid, digit   digit stream; accepted when digit_valid & digit_ready
//   digit_ready          high in RUN
//   rem_valid, rem_neg   final remainder sign, consumed in WAIT_REM
//   q_out, out_valid     corrected quotient, one-cycle update pulse
//   busy                 high in RUN and WAIT_REM
//   err                  sticky illegal-digit flag, cleared by start
module otf_conv4
  import srt4_pkg::*;
#(
  parameter int ITER = 4,
  parameter int W    = 2 * ITER
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         digit_valid,
  input  logic [3:0]   digit,
  output logic         digit_ready,
  input  logic         rem_valid,
  input  logic         rem_neg,
  output logic [W-1:0] q_out,
  output logic         out_valid,
  output logic         busy,
  output logic         err
);

  localparam int CW = $clog2(ITER + 1);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  otf_state_e   state_q;
  logic [W-1:0] q_q, qm_q, q_d, qm_d, q_out_q;
  logic [CW-1:0] cnt_q;
  logic         rdy_q, busy_q, err_q, out_valid_q;
  dig_dec_t     dec;

  assign dec = dig_decode(digit);

  otf_step #(.W(W)) u_step (
    .q_i    (q_q),
    .qm_i   (qm_q),
    .dval_i (dec.val),
    .q_o    (q_d),
    .qm_o   (qm_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      q_q         <= '0;
      qm_q        <= '1;
      cnt_q       <= '0;
      q_out_q     <= '0;
      out_valid_q <= 1'b0;
      rdy_q       <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (start) begin
        // Abort/restart: any digit or remainder sign this cycle is dropped.
        state_q <= RUN;
        q_q     <= '0;
        qm_q    <= '1;
        cnt_q   <= '0;
        err_q   <= 1'b0;
        rdy_q   <= 1'b1;
        busy_q  <= 1'b1;
      end else begin
        unique case (state_q)
          RUN: begin
            if (digit_valid) begin
              q_q   <= q_d;
              qm_q  <= qm_d;
              cnt_q <= cnt_q + 1'b1;
              if (dec.ill) err_q <= 1'b1;
              if (cnt_q == LAST) begin
                state_q <= WAIT_REM;
                rdy_q   <= 1'b0;
              end
            end
          end
          WAIT_REM: begin
            if (rem_valid) begin
              q_out_q     <= rem_neg ? qm_q : q_q;
              out_valid_q <= 1'b1;
              state_q     <= IDLE;
              busy_q      <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign digit_ready = rdy_q;
  assign busy        = busy_q;
  assign err         = err_q;
  assign q_out       = q_out_q;
  assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_otf_conv4.sv
module tb_otf_conv4;

  localparam int ITER = 4;
  localparam int W    = 8;

  localparam logic [3:0] P2 = 4'b1000, P1 = 4'b0100, Z = 4'b0000,
                         M1 = 4'b0010, M2 = 4'b0001, BAD = 4'b1100;

  logic         clk = 1'b0;
  logic         reset, start, digit_valid, rem_valid, rem_neg;
  logic [3:0]   digit;
  logic         digit_ready, out_valid, busy, err;
  logic [W-1:0] q_out;

  int n_tests = 0;
  int n_fail  = 0;

  otf_conv4 #(.ITER(ITER)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .digit_valid (digit_valid),
    .digit       (digit),
    .digit_ready (digit_ready),
    .rem_valid   (rem_valid),
    .rem_neg     (rem_neg),
    .q_out       (q_out),
    .out_valid   (out_valid),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int dval(input logic [3:0] d);
    case (d)
      P2: return 2;
      P1: return 1;
      M1: return -1;
      M2: return -2;
      default: return 0;
    endcase
  endfunction

  // Full transaction; returns q_out after the pulse and edges from start to out_valid.
  task automatic run_txn(input string tag, input logic [15:0] digs, input logic rn,
                         input int max_stall, input logic [W-1:0] exp, input logic chk_lat);
    int lat;
    lat = 0;
    start = 1'b1; tick(); start = 1'b0;
    chk({tag, ".rdy"}, {31'd0, digit_ready}, 32'd1);
    for (int i = 0; i < ITER; i++) begin
      int s;
      s = (max_stall > 0) ? $urandom_range(0, max_stall) : 0;
      for (int k = 0; k < s; k++) begin
        digit_valid = 1'b0; tick(); lat++;
      end
      digit_valid = 1'b1; digit = digs[15-4*i -: 4];
      tick(); lat++;
    end
    digit_valid = 1'b0; digit = Z;
    rem_valid = 1'b1; rem_neg = rn;
    tick(); lat++;
    rem_valid = 1'b0; rem_neg = 1'b0;
    chk({tag, ".ov"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".q"}, {24'd0, q_out}, {24'd0, exp});
    if (chk_lat) chk({tag, ".lat"}, lat, ITER + 1);
    tick();
    chk({tag, ".ov_off"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; digit_valid = 1'b0; digit = Z;
    rem_valid = 1'b0; rem_neg = 1'b0;
    tick(); tick();
    chk("rst.q",    {24'd0, q_out}, 32'd0);
    chk("rst.ov",   {31'd0, out_valid}, 32'd0);
    chk("rst.rdy",  {31'd0, digit_ready}, 32'd0);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.err",  {31'd0, err}, 32'd0);
    reset = 1'b0;
    tick();

    run_txn("d1",  {P2, M1, Z, P1}, 1'b0, 0, 8'h71, 1'b1);
    run_txn("d1n", {P2, M1, Z, P1}, 1'b1, 0, 8'h70, 1'b1);
    run_txn("m2",  {M2, M2, M2, M2}, 1'b0, 0, 8'h56, 1'b0);
    run_txn("m2n", {M2, M2, M2, M2}, 1'b1, 0, 8'h55, 1'b0);
    run_txn("z",   {Z, Z, Z, Z},     1'b1, 0, 8'hFF, 1'b0);
    chk("z.err", {31'd0, err}, 32'd0);

    run_txn("bad", {P1, BAD, P1, P1}, 1'b0, 0, 8'h45, 1'b0);
    chk("bad.err", {31'd0, err}, 32'd1);
    tick();
    chk("bad.sticky", {31'd0, err}, 32'd1);
    start = 1'b1; tick(); start = 1'b0;
    chk("bad.clr", {31'd0, err}, 32'd0);

    // abort after two digits
    digit_valid = 1'b1; digit = M2; tick(); tick();
    digit_valid = 1'b0;
    run_txn("abort", {P1, P1, P1, P1}, 1'b0, 0, 8'h55, 1'b0);

    // rem_valid during RUN is ignored
    start = 1'b1; tick(); start = 1'b0;
    digit_valid = 1'b1; digit = P2; tick(); tick();
    digit_valid = 1'b0; rem_valid = 1'b1; rem_neg = 1'b1; tick();
    rem_valid = 1'b0; rem_neg = 1'b0;
    chk("remrun.ov",   {31'd0, out_valid}, 32'd0);
    chk("remrun.rdy",  {31'd0, digit_ready}, 32'd1);
    digit_valid = 1'b1; digit = P2; tick(); tick();
    digit_valid = 1'b0; rem_valid = 1'b1; tick(); rem_valid = 1'b0;
    chk("remrun.q", {24'd0, q_out}, 32'hAA);
    chk("remrun.ov2", {31'd0, out_valid}, 32'd1);
    tick();

    // digits and rem_valid in IDLE are ignored
    digit_valid = 1'b1; digit = M2; tick(); tick();
    digit_valid = 1'b0; rem_valid = 1'b1; tick(); rem_valid = 1'b0;
    chk("idle.ov",   {31'd0, out_valid}, 32'd0);
    chk("idle.rdy",  {31'd0, digit_ready}, 32'd0);
    chk("idle.busy", {31'd0, busy}, 32'd0);
    chk("idle.q",    {24'd0, q_out}, 32'hAA);

    // reset mid-RUN, with err set
    start = 1'b1; tick(); start = 1'b0;
    digit_valid = 1'b1; digit = BAD; tick(); digit = P1; tick();
    digit_valid = 1'b0;
    chk("mid.err_pre", {31'd0, err}, 32'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("mid.q",    {24'd0, q_out}, 32'd0);
    chk("mid.rdy",  {31'd0, digit_ready}, 32'd0);
    chk("mid.busy", {31'd0, busy}, 32'd0);
    chk("mid.err",  {31'd0, err}, 32'd0);
    chk("mid.ov",   {31'd0, out_valid}, 32'd0);
    tick();

    // random back-to-back with stalls against a reference model
    for (int t = 0; t < 8; t++) begin
      logic [3:0]  tab [5];
      logic [15:0] digs;
      logic        rn;
      int          sum;
      tab[0] = P2; tab[1] = P1; tab[2] = Z; tab[3] = M1; tab[4] = M2;
      sum = 0;
      for (int i = 0; i < ITER; i++) begin
        logic [3:0] d;
        d = tab[$urandom_range(0, 4)];
        digs[15-4*i -: 4] = d;
        sum = sum * 4 + dval(d);
      end
      rn = 1'($urandom_range(0, 1));
      sum = sum - int'(rn);
      run_txn($sformatf("rnd%0d", t), digs, rn, 2, sum[7:0], 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/otf_conv4.md
# otf_conv4

Radix-4 on-the-fly quotient converter: consumes the signed quotient digits produced each iteration by the radix-4 SRT quotient-digit selection table and assembles the conventional two's-complement quotient without a final carry-propagate add. It sits at the output end of the SRT divider datapath. Iteration control drives its digit stream; the remainder sign logic supplies the final correction. One quotient is assembled per start/done transaction.

## Interface
- ITER, 4: number of radix-4 digits per quotient; quotient width W = 2*ITER
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  begin new quotient; clears Q/QM and the digit counter
- digit_valid  in  1  digit present this cycle
- digit  in  4  one-hot signed digit: [3]=+2, [2]=+1, [1]=-1, [0]=-2, 0000=0
- digit_ready  out  1  high while in RUN (digit accepted when digit_valid & digit_ready)
- rem_valid  in  1  final remainder sign present
- rem_neg  in  1  final remainder negative: select QM (Q-1)
- q_out  out  W  corrected quotient, two's complement mod 2^W
- out_valid  out  1  one-cycle pulse when q_out is updated
- busy  out  1  high in RUN and WAIT_REM
- err  out  1  sticky: a non-one-hot, nonzero digit was accepted; cleared by start or reset

## Operation
- Registers Q and QM (QM == Q-1 mod 2^W at all times), each W bits, and a digit counter 0..ITER.
- On start: Q <= 0, QM <= all ones, count <= 0, err <= 0, state <= RUN.
- Per accepted digit q:
  - Q <= (q >= 0) ? 4Q + q : 4QM + (4+q)
  - QM <= (q > 0) ? 4Q + (q-1) : 4QM + (3+q)
  - Arithmetic is mod 2^W; the low two bits are replaced, never added.
- Illegal digit (more than one bit set): err <= 1; digit treated as 0; still counted.
- States:
  - IDLE: start goes to RUN; digits and rem_valid are ignored.
  - RUN: accepting the ITER-th digit goes to WAIT_REM.
  - WAIT_REM: rem_valid loads q_out <= rem_neg ? QM : Q and sets out_valid for one cycle; state goes to IDLE.
- q_out holds its value until the next completed transaction.
- Simultaneous events:
  - start has priority in any state, including an abort mid-RUN/WAIT_REM. Any digit_valid or rem_valid in that cycle is dropped.
  - rem_valid asserted during RUN is ignored.

## Timing
- Reset values: q_out=0, out_valid=0, digit_ready=0, busy=0, err=0, state=IDLE, Q=0, QM=all ones, count=0.
- digit_ready and busy are high from the cycle after start.
- Throughput: one digit per cycle, no bubbles required.
- Latency: out_valid asserts the cycle after rem_valid is sampled in WAIT_REM. Minimum start-to-out_valid is ITER+2 cycles.
- Reset asserted mid-operation returns to reset values on the next edge; any partial quotient is discarded.

## Structure
- Package srt4_pkg holds:
  - digit bit positions (DIG_P2=3, DIG_P1=2, DIG_M1=1, DIG_M2=0);
  - the state enum (IDLE, RUN, WAIT_REM);
  - a function decoding a one-hot digit to a signed 3-bit value plus an illegal flag.
- Sub-module otf_step (combinational, parameter W) computes next Q/QM from Q, QM and the digit. The top level holds the FSM, counter and registers.

## Test plan
- ITER=4; start, digits +2,-1,0,+1, rem_valid with rem_neg=0: q_out=0x71 (113), out_valid one cycle, 6 cycles after start. Repeat with rem_neg=1: q_out=0x70.
- Digits -2,-2,-2,-2, rem_neg=0: q_out=0x56 (-170 mod 256). With rem_neg=1: 0x55.
- Digits 0,0,0,0, rem_neg=1: q_out=0xFF. err=0 throughout.
- Digit 4'b1100 in the second slot of +1,1100,+1,+1: err=1 (sticky), result equals +1,0,+1,+1 = 0x45. A following start clears err.
- Protocol edge cases:
  - start asserted after 2 digits aborts; a fresh 4-digit sequence (+1,+1,+1,+1) gives 0x55.
  - rem_valid during RUN is ignored.
  - digit_valid in IDLE is ignored.
  - reset mid-RUN returns all outputs to 0.
- Back-to-back transactions with digit_valid gaps (random stalls): q_out matches a reference model sum(q_i*4^(ITER-1-i)) - rem_neg, taken mod 2^W.
